// File: rtl/bus_response_serializer.sv
// Tail-of-bus read response serializer: buffers completed reads and streams ASCII frames to the UART.
// Build option ECHO_ADDR_EN: also echo the read address in each frame ('M' aaaa ' ' dddd CR LF).
module bus_response_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o,
    output logic        busy_o
);
    // state | meaning
    // IDLE  | no frame on the wire; pops the FIFO head when an entry is available
    // SEND  | frame register is streamed one byte per accepted handshake

`ifdef ECHO_ADDR_EN
    localparam int         ENTRY_W  = 32;
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam int         ENTRY_W  = 16;
    localparam logic [3:0] LAST_IDX = 4'd6;
`endif
    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_next;
    logic [3:0]          idx, idx_next;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [ENTRY_W-1:0]  frame;
    logic [ENTRY_W-1:0]  entry_in;
    logic                avail_q;
    logic                push, pop, full, push_ok;
    logic [7:0]          frame_byte;
    logic                unused_inputs;

`ifdef ECHO_ADDR_EN
    assign entry_in      = {addr_i, rdata_i};
    assign unused_inputs = ^wdata_i;
`else
    assign entry_in      = rdata_i;
    assign unused_inputs = ^{wdata_i, addr_i};
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

    assign push    = valid_i && !rw_i;
    assign full    = (count == FULL_CNT);
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            4'd0:    frame_byte = 8'h4D;
`ifdef ECHO_ADDR_EN
            4'd1:    frame_byte = hex_char(frame[31:28]);
            4'd2:    frame_byte = hex_char(frame[27:24]);
            4'd3:    frame_byte = hex_char(frame[23:20]);
            4'd4:    frame_byte = hex_char(frame[19:16]);
            4'd5:    frame_byte = 8'h20;
            4'd6:    frame_byte = hex_char(frame[15:12]);
            4'd7:    frame_byte = hex_char(frame[11:8]);
            4'd8:    frame_byte = hex_char(frame[7:4]);
            4'd9:    frame_byte = hex_char(frame[3:0]);
            4'd10:   frame_byte = 8'h0D;
            4'd11:   frame_byte = 8'h0A;
`else
            4'd1:    frame_byte = hex_char(frame[15:12]);
            4'd2:    frame_byte = hex_char(frame[11:8]);
            4'd3:    frame_byte = hex_char(frame[7:4]);
            4'd4:    frame_byte = hex_char(frame[3:0]);
            4'd5:    frame_byte = 8'h0D;
            4'd6:    frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        pop        = 1'b0;
        valid_o    = 1'b0;
        data_o     = 8'h00;
        case (state)
            IDLE: begin
                // avail_q lags the count by a cycle, so a fresh entry into an empty FIFO waits one extra cycle
                if (avail_q && (count != '0)) begin
                    pop        = 1'b1;
                    idx_next   = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                valid_o = 1'b1;
                data_o  = frame_byte;
                if (ready_i) begin
                    if (idx == LAST_IDX) begin
                        idx_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= entry_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame      <= '0;
            avail_q    <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            count   <= count_next;
            avail_q <= (count != '0);
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                frame  <= mem[rd_ptr];
            end
            if (push && full && !pop)
                overflow_o <= 1'b1;
            busy_o <= (count_next != '0) || (state_next == SEND);
        end
    end

endmodule

// File: tb/tb_bus_response_serializer.sv
// Bench for bus_response_serializer: constant frame table, hand sequences for multi-cycle cases,
// and a randomized run checked against a byte-queue model of the response stream.
module tb_bus_response_serializer;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i, ready_i;
    logic [7:0]  data_o;
    logic        valid_o, overflow_o, busy_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic       hold_pend = 1'b0;
    logic [7:0] held = 8'h00;

    bus_response_serializer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] rdata;
        int          n;
        logic [95:0] bytes;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hex_of(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    task automatic push_frame(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back(8'h4D);
`ifdef ECHO_ADDR_EN
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_of(int'((a >> (4 * i)) & 16'hF)));
        exp_q.push_back(8'h20);
`endif
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_of(int'((d >> (4 * i)) & 16'hF)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input bit model);
        valid_i = 1'b1; rw_i = 1'b0; addr_i = a; rdata_i = d;
        if (model) push_frame(a, d);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic check_frame(input logic [15:0] a, input logic [15:0] d, input int n, input logic [95:0] bytes);
        do_read(a, d, 1'b1);
        chk("busy_after_read", busy_o, 1'b1);
        chk("gap_valid_n", valid_o, 1'b0);
        tick();
        chk("gap_valid_n1", valid_o, 1'b0);
        tick();
        for (int k = 0; k < n; k++) begin
            chk("frame_valid", valid_o, 1'b1);
            chk("frame_byte", data_o, bytes[(n - 1 - k) * 8 +: 8]);
            tick();
        end
        chk("frame_end_valid", valid_o, 1'b0);
        chk("frame_end_busy", busy_o, 1'b0);
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_bytes_left required=0", exp_q.size());
        end
        tick();
        tick();
    endtask

    // Stream monitor: every accepted byte is compared with the model queue; stalled bytes must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", valid_o, 1'b1);
                chk("hold_data", data_o, held);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra actual=%0h required=none", data_o);
                end else begin
                    chk("stream_byte", data_o, exp_q.pop_front());
                end
            end
            hold_pend = valid_o && !ready_i;
            held      = data_o;
        end
    end

    initial begin
        logic [7:0] got [$];
        int  issued, started, bound;
        bit  tog, prev_v;
        logic [95:0] bp_bytes, rst_bytes;
        int  bp_n;

`ifdef ECHO_ADDR_EN
        tbl[0] = '{16'h0010, 16'h0C0D, 12, 96'h4D_30_30_31_30_20_30_43_30_44_0D_0A};
        tbl[1] = '{16'h0003, 16'hBEEF, 12, 96'h4D_30_30_30_33_20_42_45_45_46_0D_0A};
        tbl[2] = '{16'hFFFF, 16'h0000, 12, 96'h4D_46_46_46_46_20_30_30_30_30_0D_0A};
        tbl[3] = '{16'hA1B2, 16'h9C3E, 12, 96'h4D_41_31_42_32_20_39_43_33_45_0D_0A};
        bp_n = 12; bp_bytes  = 96'h4D_30_30_30_30_20_30_30_41_35_0D_0A;
        rst_bytes = 96'h4D_30_30_30_30_20_37_46_30_30_0D_0A;
`else
        tbl[0] = '{16'h0003, 16'hBEEF, 7, 96'h4D_42_45_45_46_0D_0A};
        tbl[1] = '{16'h1234, 16'h00A5, 7, 96'h4D_30_30_41_35_0D_0A};
        tbl[2] = '{16'hFFFF, 16'h0000, 7, 96'h4D_30_30_30_30_0D_0A};
        tbl[3] = '{16'h0000, 16'hF09C, 7, 96'h4D_46_30_39_43_0D_0A};
        bp_n = 7; bp_bytes  = 96'h4D_30_30_41_35_0D_0A;
        rst_bytes = 96'h4D_37_46_30_30_0D_0A;
`endif

        rst_n = 1'b0; addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);

        for (int i = 0; i < 4; i++)
            check_frame(tbl[i].addr, tbl[i].rdata, tbl[i].n, tbl[i].bytes);

        // Writes must never produce a frame
        valid_i = 1'b1; rw_i = 1'b1; wdata_i = 16'h1234; rdata_i = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("write_valid", valid_o, 1'b0);
            chk("write_busy", busy_o, 1'b0);
        end
        valid_i = 1'b0; rw_i = 1'b0;
        tick();

        // Backpressure: ready toggles every cycle
        ready_i = 1'b0;
        do_read(16'h0000, 16'h00A5, 1'b1);
        tog = 1'b1;
        bound = 0;
        got.delete();
        while (got.size() < bp_n && bound < 80) begin
            ready_i = tog;
            tog = !tog;
            if (valid_o && ready_i) got.push_back(data_o);
            tick();
            bound++;
        end
        chk("bp_count", got.size(), bp_n);
        for (int k = 0; k < got.size() && k < bp_n; k++)
            chk("bp_byte", got[k], bp_bytes[(bp_n - 1 - k) * 8 +: 8]);
        ready_i = 1'b1;
        drain(50);

        // Overflow: six reads into a stalled four-entry FIFO; the sixth is dropped
        ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            do_read(16'h0100 + 16'(i), 16'(i), i <= 5);
            if (i == 5) chk("ovf_not_yet", overflow_o, 1'b0);
            valid_i = (i < 6);
        end
        valid_i = 1'b0;
        chk("ovf_set", overflow_o, 1'b1);
        chk("ovf_busy", busy_o, 1'b1);
        ready_i = 1'b1;
        drain(200);
        chk("ovf_sticky", overflow_o, 1'b1);
        chk("ovf_drained_busy", busy_o, 1'b0);

        // Reset in the middle of a frame
        do_read(16'h0042, 16'h1111, 1'b1);
        tick(); tick();
        chk("mid_frame_start", valid_o, 1'b1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_overflow", overflow_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_data", data_o, 8'h00);
        check_frame(16'h0000, 16'h7F00, bp_n, rst_bytes);

        // Randomized traffic against the byte-queue model, never exceeding FIFO capacity
        issued = 0; started = 0; prev_v = valid_o;
        for (int c = 0; c < 600; c++) begin
            int r;
            if (valid_o && !prev_v) started++;
            prev_v = valid_o;
            ready_i = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 2);
            valid_i = 1'b0;
            if (r == 0 && (issued - started) < FIFO_DEPTH) begin
                valid_i = 1'b1; rw_i = 1'b0;
                addr_i = 16'($urandom); rdata_i = 16'($urandom);
                push_frame(addr_i, rdata_i);
                issued++;
            end else if (r == 1) begin
                valid_i = 1'b1; rw_i = 1'b1;
                addr_i = 16'($urandom); wdata_i = 16'($urandom); rdata_i = 16'($urandom);
            end
            tick();
        end
        valid_i = 1'b0; rw_i = 1'b0; ready_i = 1'b1;
        drain(500);
        chk("rand_overflow", overflow_o, 1'b0);
        chk("rand_busy", busy_o, 1'b0);
        chk("rand_valid", valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
